df_avg_filter_param: RTL
========================

Name: df_avg_filter_param

Overview:
Parametrised successor to the fixed 8-bit digital filter. It is a moving-average (boxcar) filter with a runtime-selectable window of 2^k samples and a valid handshake on input and output. It sits behind the top-level input synchronisers: data and config arrive already synchronised to clk, and out_data drives the output pins directly. It adds runtime window selection, history flush on reconfiguration, fill tracking and input/output valid qualification.

Parameters:
DATA_W, 8, sample width in bits (unsigned)
LOG2_MAX_WIN, 3, log2 of the maximum window; history depth = 2^LOG2_MAX_WIN
CFG_W, 3, width of cfg_in; must satisfy 2^CFG_W > LOG2_MAX_WIN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cfg_en  in  1  load cfg_in into the window-select register this cycle
cfg_in  in  CFG_W  requested window exponent k (window = 2^k)
in_valid  in  1  in_data carries a new sample this cycle
in_data  in  DATA_W  input sample, unsigned
out_valid  out  1  one-cycle pulse: out_data updated with a new average
out_data  out  DATA_W  registered average; holds between pulses
win_sel  out  $clog2(LOG2_MAX_WIN+1)  active window exponent
filled  out  1  high once the history holds at least 2^win_sel samples since the last flush

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, win_sel=0 (pass-through), filled=0, sum=0, wr_ptr=0, fill_cnt=0, FSM=FILL. History RAM contents are don't-care (never read before being written after a flush).
- Window select: on cfg_en, win_sel <= min(cfg_in, LOG2_MAX_WIN). Every cfg_en is a flush, even if the value is unchanged: sum=0, fill_cnt=0, filled=0, FSM=FILL. out_data holds its value; out_valid=0 that cycle.
- cfg_en and in_valid in the same cycle: cfg wins; the sample is dropped.
- N = 2^win_sel. History is a circular buffer of depth 2^LOG2_MAX_WIN, written at wr_ptr; wr_ptr increments modulo depth on each accepted sample.
- Oldest sample is read at (wr_ptr - N) mod depth. It counts as 0 while fill_cnt < N.
- Accumulator width DATA_W+LOG2_MAX_WIN; it cannot overflow. Each accepted sample: sum <= sum + in_data - oldest.
- Average = (sum + in_data - oldest) >> win_sel, truncated with no rounding. The result fits in DATA_W by construction.
- FSM:
  - FILL: on each accepted sample, fill_cnt++. On the sample where fill_cnt reaches N, go to RUN, set filled=1 and emit the first output.
  - RUN: every accepted sample emits an output.
  - fill_cnt saturates at N.
- Latency: out_valid pulses exactly 1 cycle after the accepting in_valid edge; out_data updates on that same edge. No backpressure; one sample per cycle is sustained.
- win_sel=0: the FSM goes straight to RUN on the first sample, giving a 1-cycle registered pass-through.
- wr_ptr wraps from depth-1 to 0 without a bubble or glitch.
- No outputs are produced in FILL. An in_valid low cycle produces no output and changes no state.

Decomposition:
- Shared package df_pkg: the FSM state enum (FILL, RUN), default parameter constants, and a clamp function for cfg_in→win_sel.
- One sub-module, df_hist_buf: circular sample store, depth 2^LOG2_MAX_WIN, DATA_W wide, with one synchronous-write port and one combinational-read port (read address = wr_ptr - N).
- Accumulator, FSM and output register stay in df_avg_filter_param.

Test Plan:
- Pass-through: after reset (win_sel=0), in 0xA5 then 0x3C on consecutive cycles -> out_valid pulses on the next two cycles with out_data 0xA5, then 0x3C.
- Window 4: cfg 2, then samples 4, 8, 12, 16 -> no out_valid for the first three; after 16, out_data=10 and filled=1. Next samples 20, 24 -> 14, 18.
- Clamp and full scale: cfg 7 -> win_sel=3; eight samples of 0xFF -> first output 0xFF; then one 0x00 -> 0xDF (1785>>3=223).
- Reconfigure mid-run: window 4 in RUN, cfg_en with cfg 1 asserted together with in_valid -> sample dropped, filled=0, out_data held. Samples 6, 9 -> out_data 7 after the second sample only.
- Wrap and gaps: window 8, 20 samples 0..19 with in_valid gaps inserted -> each output equals floor(sum of last 8 / 8), e.g. after 19: 15. No spurious out_valid during gaps.
- Async reset asserted mid-RUN -> all outputs are 0 immediately (no clock edge needed). After release, behaves as pass-through.

Source files
------------

// File: rtl/df_pkg.sv
// Shared definitions for the moving-average filter slice.
// Contents:
//   df_state_e      - filter FSM state (FILL while the window is priming, RUN after)
//   DF_* constants  - default parameter values used by the filter and its history store
//   df_clamp_win    - limits a requested window exponent to the largest supported one
package df_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } df_state_e;

  localparam int unsigned DF_DATA_W       = 8;
  localparam int unsigned DF_LOG2_MAX_WIN = 3;
  localparam int unsigned DF_CFG_W        = 3;

  // Requests larger than the history depth fall back to the widest window.
  function automatic int unsigned df_clamp_win(input int unsigned cfg,
                                               input int unsigned maxWin);
    return (cfg > maxWin) ? maxWin : cfg;
  endfunction

endpackage

// File: rtl/df_hist_buf.sv
// Circular sample store for the moving-average filter.
// One synchronous write port and one combinational read port; the read sees the
// old contents of a location that is written on the same edge.
// Ports:
//   clk      in  clock, rising edge
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational)
module df_hist_buf
  import df_pkg::*;
#(
  parameter int unsigned DATA_W = DF_DATA_W,
  parameter int unsigned ADDR_W = DF_LOG2_MAX_WIN
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // No reset: every location is written after a flush before it is read.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/df_avg_filter_param.sv
// Moving-average (boxcar) filter with a runtime-selectable window of 2^k samples.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   cfg_en     in  load cfg_in as the new window exponent and flush the history
//   cfg_in     in  requested window exponent (clamped to LOG2_MAX_WIN)
//   in_valid   in  in_data holds a new sample this cycle
//   in_data    in  unsigned input sample
//   out_valid  out one-cycle pulse when out_data carries a new average
//   out_data   out registered average, holds between pulses
//   win_sel    out active window exponent
//   filled     out history holds a full window of samples since the last flush
module df_avg_filter_param
  import df_pkg::*;
#(
  parameter int unsigned DATA_W       = DF_DATA_W,
  parameter int unsigned LOG2_MAX_WIN = DF_LOG2_MAX_WIN,
  parameter int unsigned CFG_W        = DF_CFG_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_en,
  input  logic [CFG_W-1:0]                  cfg_in,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              out_valid,
  output logic [DATA_W-1:0]                 out_data,
  output logic [$clog2(LOG2_MAX_WIN+1)-1:0] win_sel,
  output logic                              filled
);

  localparam int unsigned WS_W  = $clog2(LOG2_MAX_WIN + 1);
  localparam int unsigned PTR_W = LOG2_MAX_WIN;
  localparam int unsigned CNT_W = LOG2_MAX_WIN + 1;
  localparam int unsigned ACC_W = DATA_W + LOG2_MAX_WIN;

  df_state_e         state_q, state_d;
  logic [WS_W-1:0]   winSel_q, winSel_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  fillCnt_q, fillCnt_d;
  logic              filled_q, filled_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;

  logic              accept;
  logic [CNT_W-1:0]  nWin;
  logic [PTR_W-1:0]  rdAddr;
  logic [DATA_W-1:0] rdData;
  logic [DATA_W-1:0] oldest;
  logic [ACC_W-1:0]  sumNext;

  assign accept = in_valid & ~cfg_en;
  assign nWin   = CNT_W'(1) << winSel_q;
  // With the widest window nWin truncates to 0 here, so the read hits the slot
  // about to be overwritten, which is exactly the oldest sample.
  assign rdAddr = wrPtr_q - nWin[PTR_W-1:0];

  df_hist_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_hist (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wrPtr_q),
    .wdata_i (in_data),
    .raddr_i (rdAddr),
    .rdata_o (rdData)
  );

  // Slots left over from before a flush must not leave the window.
  assign oldest  = (fillCnt_q < nWin) ? '0 : rdData;
  // Intermediate overflow wraps harmlessly; the subtraction brings it back in range.
  assign sumNext = sum_q + ACC_W'(in_data) - ACC_W'(oldest);

  always_comb begin
    state_d    = state_q;
    winSel_d   = winSel_q;
    sum_d      = sum_q;
    wrPtr_d    = wrPtr_q;
    fillCnt_d  = fillCnt_q;
    filled_d   = filled_q;
    outValid_d = 1'b0;
    outData_d  = outData_q;
    if (cfg_en) begin
      // Reconfiguration always flushes, even when the exponent is unchanged.
      winSel_d  = WS_W'(df_clamp_win(32'(cfg_in), LOG2_MAX_WIN));
      sum_d     = '0;
      fillCnt_d = '0;
      filled_d  = 1'b0;
      state_d   = FILL;
    end else if (in_valid) begin
      sum_d   = sumNext;
      wrPtr_d = wrPtr_q + PTR_W'(1);
      unique case (state_q)
        FILL: begin
          fillCnt_d = fillCnt_q + CNT_W'(1);
          if ((fillCnt_q + CNT_W'(1)) == nWin) begin
            state_d    = RUN;
            filled_d   = 1'b1;
            outValid_d = 1'b1;
            outData_d  = DATA_W'(sumNext >> winSel_q);
          end
        end
        RUN: begin
          outValid_d = 1'b1;
          outData_d  = DATA_W'(sumNext >> winSel_q);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      winSel_q   <= '0;
      sum_q      <= '0;
      wrPtr_q    <= '0;
      fillCnt_q  <= '0;
      filled_q   <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      winSel_q   <= winSel_d;
      sum_q      <= sum_d;
      wrPtr_q    <= wrPtr_d;
      fillCnt_q  <= fillCnt_d;
      filled_q   <= filled_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign win_sel   = winSel_q;
  assign filled    = filled_q;

endmodule
